uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver that consumes the serial line driven by uart_tx, either in loopback or from an external pin. It deserialises 8N1 frames at a parameterised bit rate and presents each received byte with a single-cycle valid strobe. It also flags framing errors and line breaks, so a downstream FIFO or register block can capture the data or discard it.

Parameters:
BIT_RATE, 9600, serial bit rate in bits/s.
CLK_HZ, 50000000, system clock frequency in Hz.
PAYLOAD_BITS, 8, data bits per frame, sent LSB first.
CYCLES_PER_BIT (localparam), CLK_HZ/BIT_RATE, integer-truncated; 5208 at the default values.

Ports:
clk  input  1  system clock, rising-edge.
resetn  input  1  asynchronous active-low reset.
uart_rxd  input  1  serial line, asynchronous to clk, idles high.
uart_rx_en  input  1  receive enable; frames start only while this is high.
uart_rx_valid  output  1  one-cycle strobe: uart_rx_data holds a good byte.
uart_rx_data  output  PAYLOAD_BITS  last received byte, held between strobes.
uart_rx_frame_err  output  1  one-cycle strobe: stop bit sampled low.
uart_rx_break  output  1  one-cycle strobe: all data bits 0 and stop bit 0.

Behaviour:
- Reset (async, resetn=0) values:
  - Outputs: valid, frame_err and break are 0; data is 0.
  - FSM is in IDLE; cycle and bit counters are 0.
  - Both synchroniser flops are 1.
- Synchroniser: uart_rxd passes through 2 flops before any use. All sampling uses the synchronised signal rxs.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - If uart_rx_en=1 and rxs goes 1->0 (registered previous value was 1), go to START and clear the cycle counter.
  - Low-to-high edges and a steady low line are ignored.
- START:
  - Counts CYCLES_PER_BIT/2 cycles, then samples rxs.
  - rxs=1: treat as a glitch or false start and return to IDLE with no strobe.
  - rxs=0: go to DATA and clear the counter.
- DATA:
  - Samples rxs every CYCLES_PER_BIT cycles, which is mid-bit.
  - Each sample shifts into the MSB of the shift register (shift right), so the first bit received ends up as the LSB.
  - After PAYLOAD_BITS samples, go to STOP.
- STOP: after CYCLES_PER_BIT cycles, sample rxs.
  - rxs=1: uart_rx_data <= shift register, and uart_rx_valid=1 for exactly 1 cycle. Go to IDLE.
  - rxs=0: uart_rx_frame_err=1 for 1 cycle; uart_rx_data is not updated. If the shift register is all zero, uart_rx_break=1 in the same cycle. Go to WAIT_HIGH.
- WAIT_HIGH: stay until rxs=1, then go to IDLE. This prevents a held-low line from re-triggering frames.
- uart_rx_en deasserted in any non-IDLE state: abort to IDLE on the next edge. No strobe is issued and uart_rx_data is unchanged.
- Latency: valid rises (PAYLOAD_BITS+1)*CYCLES_PER_BIT + CYCLES_PER_BIT/2 + 3..4 clk cycles after the uart_rxd falling edge at the pin. The extra 3..4 cycles cover the synchroniser and edge detect.
- Back-to-back frames: a new start bit may begin immediately after the stop bit. IDLE is re-entered half a bit before the stop bit ends, so no frame is lost.
- Strobe exclusivity: valid and frame_err are never high together. Break is high only together with frame_err.
- Counter width: $clog2(CYCLES_PER_BIT+1) bits. The bit counter is $clog2(PAYLOAD_BITS+1) bits.
- Reset mid-frame: immediate return to the reset values. The next frame is received correctly once resetn=1 and the line has been seen high.

Test Plan:
- Single frame: send 0xA5 (8N1, 104166 ns per bit). Required: exactly one uart_rx_valid pulse, uart_rx_data=8'hA5, frame_err=0.
- Back-to-back frames: 0x00, 0xFF, 0x55 with no idle time between them. Required: three valid pulses carrying 00, FF, 55 in order, and no errors.
- Glitch: drive uart_rxd low for 1000 ns only. Required: no valid, no frame_err, FSM back in IDLE; a following 0x3C frame is received correctly.
- Bad stop bit: frame 0x81 with the stop bit driven 0. Required: frame_err pulses once, break=0, and uart_rx_data keeps its previous value. A break (line low for 12 bit times, then high) gives frame_err=1 and break=1 in the same cycle, then exactly one strobe and no re-trigger until the line has gone high.
- Reset mid-frame: assert resetn=0 during the data bits of 0xC3. Required: outputs return to their reset values; after release, the frame 0x5A gives data=8'h5A. Also drop uart_rx_en mid-frame: no strobe.
- Loopback: connect uart_tx.uart_txd to uart_rxd and send 20 $random bytes through uart_tx. Required: 20 valid pulses, each data value equal to the byte sent, zero frame_err.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling, byte strobe, framing-error and break strobes
module uart_rx #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50000000,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_frame_err,
  output logic                    uart_rx_break
);
  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int CW = $clog2(CYCLES_PER_BIT + 1);
  localparam int BW = $clog2(PAYLOAD_BITS + 1);
  localparam logic [CW-1:0] HALF_END = CW'(CYCLES_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_END = CW'(CYCLES_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(PAYLOAD_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t state;
  logic rx_s1, rxs, rx_prev;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_cnt;
  logic [PAYLOAD_BITS-1:0] sr;
  logic half_tick, bit_tick;
  assign half_tick = cnt == HALF_END;
  assign bit_tick = cnt == BIT_END;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_s1 <= 1'b1;
      rxs <= 1'b1;
      rx_prev <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      sr <= '0;
      uart_rx_valid <= 1'b0;
      uart_rx_data <= '0;
      uart_rx_frame_err <= 1'b0;
      uart_rx_break <= 1'b0;
    end else begin
      rx_s1 <= uart_rxd;
      rxs <= rx_s1;
      rx_prev <= rxs;
      uart_rx_valid <= 1'b0;
      uart_rx_frame_err <= 1'b0;
      uart_rx_break <= 1'b0;
      if (state != IDLE && !uart_rx_en) begin
        state <= IDLE;
        cnt <= '0;
        bit_cnt <= '0;
      end else begin
        case (state)
          IDLE: if (uart_rx_en && rx_prev && !rxs) begin
            state <= START;
            cnt <= '0;
          end
          START: if (half_tick) begin
            state <= rxs ? IDLE : DATA;
            cnt <= '0;
          end else cnt <= cnt + 1'b1;
          DATA: if (bit_tick) begin
            cnt <= '0;
            sr <= {rxs, sr[PAYLOAD_BITS-1:1]};
            bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) state <= STOP;
          end else cnt <= cnt + 1'b1;
          STOP: if (bit_tick) begin
            cnt <= '0;
            if (rxs) begin
              uart_rx_data <= sr;
              uart_rx_valid <= 1'b1;
              state <= IDLE;
            end else begin
              uart_rx_frame_err <= 1'b1;
              uart_rx_break <= sr == '0;
              state <= WAIT_HIGH;
            end
          end else cnt <= cnt + 1'b1;
          WAIT_HIGH: if (rxs) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx against a frame-level reference model
module tb_uart_rx;
  localparam int CLK_HZ = 100_000_000;
  localparam int BIT_RATE = 6_250_000;
  localparam int CPB = CLK_HZ / BIT_RATE;
  localparam int BIT_NS = CPB * 10;
  localparam int LAT = 9 * CPB + CPB / 2 + 3;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic uart_rxd = 1'b1;
  logic uart_rx_en = 1'b1;
  logic uart_rx_valid, uart_rx_frame_err, uart_rx_break;
  logic [7:0] uart_rx_data;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] vq[$];
  int vcq[$];
  logic bq[$];
  logic [7:0] exp_v[$];
  logic exp_b[$];
  logic [7:0] last_good = 8'h00;

  uart_rx #(.BIT_RATE(BIT_RATE), .CLK_HZ(CLK_HZ), .PAYLOAD_BITS(8)) dut (
    .clk(clk), .resetn(resetn), .uart_rxd(uart_rxd), .uart_rx_en(uart_rx_en),
    .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data),
    .uart_rx_frame_err(uart_rx_frame_err), .uart_rx_break(uart_rx_break)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (resetn) begin
      if (uart_rx_valid) begin
        vq.push_back(uart_rx_data);
        vcq.push_back(cyc);
      end
      if (uart_rx_frame_err) bq.push_back(uart_rx_break);
      if (uart_rx_valid || uart_rx_frame_err || uart_rx_break) begin
        total++;
        if ((uart_rx_valid && uart_rx_frame_err) || (uart_rx_break && !uart_rx_frame_err)) begin
          bad++;
          $display("FAIL strobe_excl: valid=%0b frame_err=%0b break=%0b", uart_rx_valid, uart_rx_frame_err, uart_rx_break);
        end
      end
    end
  end

  task automatic clear_q();
    vq.delete(); vcq.delete(); bq.delete(); exp_v.delete(); exp_b.delete();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic model);
    uart_rxd = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      #(BIT_NS);
    end
    uart_rxd = stop;
    #(BIT_NS);
    uart_rxd = 1'b1;
    if (model) begin
      if (stop) begin
        exp_v.push_back(d);
        last_good = d;
      end else exp_b.push_back(d == 8'h00);
    end
  endtask

  task automatic check_queues(input string name);
    total++;
    if (vq.size() != exp_v.size()) begin
      bad++;
      $display("FAIL %s valid_count: got %0d exp %0d", name, vq.size(), exp_v.size());
    end
    for (int i = 0; i < exp_v.size(); i++) begin
      total++;
      if (i >= vq.size() || vq[i] !== exp_v[i]) begin
        bad++;
        $display("FAIL %s data[%0d]: got %h exp %h", name, i, (i < vq.size()) ? vq[i] : 8'hxx, exp_v[i]);
      end
    end
    total++;
    if (bq.size() != exp_b.size()) begin
      bad++;
      $display("FAIL %s frame_err_count: got %0d exp %0d", name, bq.size(), exp_b.size());
    end
    for (int i = 0; i < exp_b.size(); i++) begin
      total++;
      if (i >= bq.size() || bq[i] !== exp_b[i]) begin
        bad++;
        $display("FAIL %s break[%0d]: got %b exp %b", name, i, (i < bq.size()) ? bq[i] : 1'bx, exp_b[i]);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total += 4;
    if (uart_rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b exp 0", uart_rx_valid); end
    if (uart_rx_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h exp 00", uart_rx_data); end
    if (uart_rx_frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b exp 0", uart_rx_frame_err); end
    if (uart_rx_break !== 1'b0) begin bad++; $display("FAIL reset_break: got %b exp 0", uart_rx_break); end
    resetn = 1'b1;
    #(BIT_NS);
  endtask

  task automatic test_single();
    int fall;
    clear_q();
    @(posedge clk);
    #3;
    fall = cyc;
    send_frame(8'hA5, 1'b1, 1'b1);
    #(2 * BIT_NS);
    check_queues("single");
    total++;
    if (vcq.size() < 1 || vcq[0] - fall < LAT || vcq[0] - fall > LAT + 1) begin
      bad++;
      $display("FAIL single_latency: got %0d exp %0d..%0d", (vcq.size() > 0) ? vcq[0] - fall : -1, LAT, LAT + 1);
    end
  endtask

  task automatic test_back_to_back();
    clear_q();
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    send_frame(8'h55, 1'b1, 1'b1);
    #(2 * BIT_NS);
    check_queues("b2b");
  endtask

  task automatic test_glitch();
    clear_q();
    uart_rxd = 1'b0;
    #40;
    uart_rxd = 1'b1;
    #(2 * BIT_NS);
    check_queues("glitch");
    clear_q();
    send_frame(8'h3C, 1'b1, 1'b1);
    #(2 * BIT_NS);
    check_queues("after_glitch");
  endtask

  task automatic test_bad_stop();
    clear_q();
    send_frame(8'h81, 1'b0, 1'b1);
    #(2 * BIT_NS);
    check_queues("bad_stop");
    total++;
    if (uart_rx_data !== last_good) begin
      bad++;
      $display("FAIL bad_stop_data_held: got %h exp %h", uart_rx_data, last_good);
    end
    clear_q();
    uart_rxd = 1'b0;
    #(12 * BIT_NS);
    uart_rxd = 1'b1;
    exp_b.push_back(1'b1);
    #(2 * BIT_NS);
    check_queues("break");
  endtask

  task automatic test_reset_mid();
    clear_q();
    fork
      send_frame(8'hC3, 1'b1, 1'b0);
      begin
        #(4 * BIT_NS);
        resetn = 1'b0;
        #20;
        total++;
        if ({uart_rx_valid, uart_rx_frame_err, uart_rx_break, uart_rx_data} !== 11'h000) begin
          bad++;
          $display("FAIL reset_mid_outputs: got v=%b fe=%b br=%b d=%h exp all 0", uart_rx_valid, uart_rx_frame_err, uart_rx_break, uart_rx_data);
        end
      end
    join
    #(BIT_NS);
    resetn = 1'b1;
    #(BIT_NS);
    send_frame(8'h5A, 1'b1, 1'b1);
    #(2 * BIT_NS);
    check_queues("reset_mid");
    clear_q();
    fork
      send_frame(8'h96, 1'b1, 1'b0);
      begin
        #(5 * BIT_NS);
        uart_rx_en = 1'b0;
      end
    join
    #(2 * BIT_NS);
    uart_rx_en = 1'b1;
    #(BIT_NS);
    check_queues("en_drop");
    total++;
    if (uart_rx_data !== last_good) begin
      bad++;
      $display("FAIL en_drop_data_held: got %h exp %h", uart_rx_data, last_good);
    end
  endtask

  task automatic test_loopback();
    clear_q();
    for (int i = 0; i < 20; i++) begin
      send_frame(8'($urandom), 1'b1, 1'b1);
      #($urandom_range(0, 3) * BIT_NS / 2 + $urandom_range(0, 9));
    end
    #(2 * BIT_NS);
    check_queues("loopback");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_bad_stop();
    test_reset_mid();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
